fast_uart: RTL and testbench

- Compact 8N1 UART transceiver (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) for high baud rates where the clock-to-baud ratio is small (down to 2 clocks per bit).
- Used as a host-side serial endpoint alongside the user-space SoC for byte-level TX/RX exchanges.
- Independent TX and RX paths share one clock and reset.

---
 rtl/fast_uart.sv | 201 ++++++++++++++++++++
 tb/tb_fast_uart.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_uart.sv
// fast_uart: compact 8N1 UART transceiver (1 start, 8 data LSB first,
// 1 stop, no parity) for small clock-to-baud ratios (>= 2 clocks per bit).
// TX and RX run concurrently from one clock and an asynchronous active-low
// reset.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   txEnable         transmit request, sampled each clock while idle
//   txData[7:0]      byte captured when a request is accepted
//   txBusy           high while a frame is being transmitted
//   rxDataAvailable  one-cycle pulse when a byte has been received
//   rxData[7:0]      last received byte, held until the next one completes
//   rx               serial input, idles high
//   tx               serial output, idles high
//
// Optional build macro: FAST_UART_FRAME_CHECK_EN
//   defined   -> a low stop-bit sample discards the byte (framing error)
//   undefined -> stop bit is not checked; every frame is reported
module fast_uart #(
  parameter int CLK_FREQ = 40000000,
  parameter int BAUD     = 9216000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txEnable,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       rxDataAvailable,
  output logic [7:0] rxData,
  input  logic       rx,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_ratio
      $error("fast_uart: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      txBusy   <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (txEnable) begin
            tx_shift <= txData;
            tx       <= 1'b0;
            txBusy   <= 1'b1;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              // tx is registered, so drive the next bit from the pre-shift copy
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            txBusy   <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic            rx_meta;
  logic            rx_sync;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state        <= RX_IDLE;
      rx_cnt          <= '0;
      rx_bit          <= '0;
      rx_shift        <= '0;
      rxData          <= '0;
      rxDataAvailable <= 1'b0;
    end else begin
      rxDataAvailable <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
`ifdef FAST_UART_FRAME_CHECK_EN
            if (rx_sync) begin
              rxData          <= rx_shift;
              rxDataAvailable <= 1'b1;
              rx_state        <= RX_IDLE;
            end else begin
              rx_state <= RX_WAIT_HIGH;
            end
`else
            rxData          <= rx_shift;
            rxDataAvailable <= 1'b1;
            // a low stop sample (e.g. break) must not be re-read as a new start
            rx_state        <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_uart.sv
// tb_fast_uart: scoreboard bench for fast_uart at default parameters.
// Expected TX frames and RX bytes are queued by the stimulus; independent
// monitors pop and compare when the DUT starts a frame or pulses
// rxDataAvailable.
module tb_fast_uart;

  localparam int CPB = 40000000 / 9216000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txEnable = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txBusy;
  logic       rxDataAvailable;
  logic [7:0] rxData;
  logic       rx_line;
  logic       tx;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;

  always #5 clk = ~clk;

  always_comb rx_line = loop ? tx : rx_drv;

  fast_uart #(.CLK_FREQ(40000000), .BAUD(9216000)) dut (
    .clk            (clk),
    .rst            (rst),
    .txEnable       (txEnable),
    .txData         (txData),
    .txBusy         (txBusy),
    .rxDataAvailable(rxDataAvailable),
    .rxData         (rxData),
    .rx             (rx_line),
    .tx             (tx)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         pulse_cnt = 0;
  bit         tx_mon_en = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // RX monitor: every pulse must match the next queued byte and last 1 cycle
  logic [7:0] rx_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && rxDataAvailable) begin
        pulse_cnt++;
        if (rx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_unexpected_pulse: got byte 0x%0h with nothing queued", rxData);
        end else begin
          rx_exp = rx_q.pop_front();
          check("rx_byte", {24'h0, rxData}, {24'h0, rx_exp});
        end
        @(negedge clk);
        check("rx_pulse_width", {31'h0, rxDataAvailable}, 32'h0);
      end
    end
  end

  // TX monitor: sample each bit mid-cell and count busy cycles
  logic       prev_busy;
  int         c;
  logic [9:0] bits;
  logic [7:0] tx_exp;
  initial begin
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (txBusy && !prev_busy) begin
        if (tx_mon_en) begin
          c = 0;
          bits = '0;
          while (txBusy && c < 100) begin
            if ((c % CPB) == (CPB / 2) && (c / CPB) < 10) bits[c / CPB] = tx;
            c++;
            @(negedge clk);
          end
          if (tx_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_unexpected_frame: got bits 0x%0h with nothing queued", bits);
          end else begin
            tx_exp = tx_q.pop_front();
            check("tx_frame", {22'h0, bits}, {22'h0, 1'b1, tx_exp, 1'b0});
            check("tx_busy_cycles", c, 10 * CPB);
          end
        end else begin
          while (txBusy) @(negedge clk);
        end
      end
      prev_busy = txBusy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_tx(input logic [7:0] d);
    txData   = d;
    txEnable = 1'b1;
    tick(1);
    txEnable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(CPB);
    end
    rx_drv = stop_bit;
    tick(CPB);
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0 || txBusy) && n < limit) begin
      tick(1);
      n++;
    end
    check("drain_in_time", {31'h0, (n < limit)}, 32'h1);
    rx_q.delete();
    tx_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p0;
  initial begin
    // reset state
    rst = 1'b0;
    tick(10);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, txBusy}, 32'h0);
    check("rst_avail", {31'h0, rxDataAvailable}, 32'h0);
    check("rst_rxdata", {24'h0, rxData}, 32'h0);
    rst = 1'b1;
    tick(5);

    // single TX frame 'H'
    tx_q.push_back(8'h48);
    send_tx(8'h48);
    wait_drain(200);
    tick(5);

    // reset in the middle of a looped-back frame
    loop = 1'b1;
    tx_mon_en = 1'b0;
    p0 = pulse_cnt;
    send_tx(8'h00);
    tick(12);
    rst = 1'b0;
    #1;
    check("abort_tx", {31'h0, tx}, 32'h1);
    check("abort_busy", {31'h0, txBusy}, 32'h0);
    @(negedge clk);
    tick(3);
    rst = 1'b1;
    tick(60);
    check("abort_no_rx", pulse_cnt - p0, 0);
    tx_mon_en = 1'b1;

    // loopback 's' then 'a'
    p0 = pulse_cnt;
    tx_q.push_back(8'h73);
    rx_q.push_back(8'h73);
    send_tx(8'h73);
    wait_drain(200);
    tx_q.push_back(8'h61);
    rx_q.push_back(8'h61);
    send_tx(8'h61);
    wait_drain(200);
    tick(10);
    check("rx_hold", {24'h0, rxData}, 32'h61);
    check("loop_pulses", pulse_cnt - p0, 2);

    // request while busy is ignored; txData change mid-frame is harmless
    tx_q.push_back(8'h77);
    rx_q.push_back(8'h77);
    send_tx(8'h77);
    tick(10);
    txData   = 8'h55;
    txEnable = 1'b1;
    tick(1);
    txEnable = 1'b0;
    wait_drain(200);
    tick(60);
    check("busy_after_ignore", {31'h0, txBusy}, 32'h0);
    loop = 1'b0;

    // one-cycle glitch
    p0 = pulse_cnt;
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(30);
    check("glitch_no_pulse", pulse_cnt - p0, 0);

    // break: one 0x00 then silence until line rises
    rx_q.push_back(8'h00);
    rx_drv = 1'b0;
    tick(60);
    check("break_one", pulse_cnt - p0, 1);
    check("break_byte", {24'h0, rxData}, 32'h0);
    tick(80);
    check("break_no_second", pulse_cnt - p0, 1);
    rx_drv = 1'b1;
    tick(10);

    // 0xA5 with a low stop bit
    p0 = pulse_cnt;
`ifdef FAST_UART_FRAME_CHECK_EN
    send_rx(8'hA5, 1'b0);
    tick(20);
    check("frame_err_no_pulse", pulse_cnt - p0, 0);
    check("frame_err_rxdata", {24'h0, rxData}, 32'h00);
`else
    rx_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b0);
    tick(20);
    check("stop_unchecked_pulse", pulse_cnt - p0, 1);
    check("stop_unchecked_rxdata", {24'h0, rxData}, 32'hA5);
`endif

    // receiver recovers for a normal frame
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    tick(20);
    check("rx_recover", {24'h0, rxData}, 32'h3C);
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
